// File: rtl/shift_right_seq_pkg.sv
// Shared definitions for the multi-cycle right shifter: default widths,
// operation encodings and the sequencer state type.
package shift_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SHW   = 5;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_SHR  = 2'b00;
    localparam mode_t MODE_SHRA = 2'b01;
    localparam mode_t MODE_ROR  = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_right_seq_if.sv
// Request/response bundle between the control unit (master) and the
// right-shift unit (slave).
interface shift_right_seq_if
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = DEF_SHW
);
    logic             start;
    logic [WIDTH-1:0] B;
    logic [SHW-1:0]   shifts;
    mode_t            mode;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Result;

    modport master (
        output start, B, shifts, mode,
        input  busy, done, Result
    );

    modport slave (
        input  start, B, shifts, mode,
        output busy, done, Result
    );
endinterface

// File: rtl/shift_right_seq_step.sv
// One-position right shifter used by shift_right_seq on every SHIFT cycle.
// Rotate-right is compiled only when SHIFT_ROR_EN is defined; otherwise
// the ROR encoding produces a logical shift.
module shift_right_step
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] acc_i,
    input  mode_t            op_i,
    output logic [WIDTH-1:0] acc_o
);

    // Select the bit shifted into the MSB according to the operation.
    always_comb begin
        acc_o = {1'b0, acc_i[WIDTH-1:1]};
        case (op_i)
            MODE_SHRA: acc_o = {acc_i[WIDTH-1], acc_i[WIDTH-1:1]};
`ifdef SHIFT_ROR_EN
            MODE_ROR:  acc_o = {acc_i[0], acc_i[WIDTH-1:1]};
`else
            MODE_ROR:  acc_o = {1'b0, acc_i[WIDTH-1:1]};
`endif
            default:   acc_o = {1'b0, acc_i[WIDTH-1:1]};
        endcase
    end

endmodule

// File: rtl/shift_right_seq.sv
// Multi-cycle right-shift unit (SHR / SHRA / optional ROR), one bit per
// clock, with a start/busy/done handshake. Result is held until the next
// accepted start. Build option: SHIFT_ROR_EN enables rotate-right.
module shift_right_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = DEF_SHW
) (
    input  logic              clock,
    input  logic              clear,
    shift_right_seq_if.slave  bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] acc_step;
    logic [SHW-1:0]   cnt_q, cnt_d;
    mode_t            op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    shift_right_step #(.WIDTH(WIDTH)) u_step (
        .acc_i (acc_q),
        .op_i  (op_q),
        .acc_o (acc_step)
    );

    // Next-state logic: capture on start, shift while count remains,
    // publish the result and pulse done for one cycle.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    acc_d   = bus.B;
                    cnt_d   = bus.shifts;
                    op_d    = bus.mode;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                busy_d = 1'b1;
                if (cnt_q != '0) begin
                    acc_d = acc_step;
                    cnt_d = cnt_q - SHW'(1);
                end else begin
                    result_d = acc_q;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; clear discards any in-flight operation.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            op_q     <= MODE_SHR;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.Result = result_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// Self-checking bench for shift_right_seq: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_shift_right_seq;

    logic clock;
    logic clear;

    int compared;
    int mismatched;
    logic [31:0] last_result;

    shift_right_seq_if #(.WIDTH(32), .SHW(5)) bus ();

    shift_right_seq #(.WIDTH(32), .SHW(5)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: whole shift done at once with native operators.
    function automatic logic [31:0] ref_shift(input logic [31:0] b, input int n, input logic [1:0] m);
        logic [63:0] dbl;
        case (m)
            2'b01: ref_shift = 32'($signed(b) >>> n);
`ifdef SHIFT_ROR_EN
            2'b10: begin
                dbl = {b, b} >> n;
                ref_shift = dbl[31:0];
            end
`endif
            default: ref_shift = b >> n;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one operation; optionally pulse a competing start at cycle 'poke'.
    task automatic run_op(input logic [31:0] b, input int n, input logic [1:0] m,
                          input logic [31:0] exp, input int poke, input string tag);
        int cyc;
        bit seen;
        @(negedge clock);
        bus.start  = 1'b1;
        bus.B      = b;
        bus.shifts = n[4:0];
        bus.mode   = m;
        @(posedge clock);
        #1;
        bus.start  = 1'b0;
        bus.B      = $urandom;
        bus.shifts = 5'($urandom);
        bus.mode   = 2'($urandom);
        check({tag, "_busy_rise"}, {31'b0, bus.busy}, 32'd1);
        check({tag, "_result_held"}, bus.Result, last_result);
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 40) begin
            if (poke > 0 && cyc == poke - 1) begin
                bus.start = 1'b1;
                bus.B     = 32'hFFFF_FFFF;
            end else if (poke > 0 && cyc == poke) begin
                bus.start = 1'b0;
            end
            @(posedge clock);
            #1;
            cyc++;
            if (bus.done) seen = 1;
        end
        bus.start = 1'b0;
        check({tag, "_latency"}, 32'(cyc), 32'(n + 1));
        check({tag, "_result"}, bus.Result, exp);
        check({tag, "_busy_done"}, {31'b0, bus.busy}, 32'd1);
        @(posedge clock);
        #1;
        check({tag, "_done_single"}, {31'b0, bus.done}, 32'd0);
        check({tag, "_busy_fall"}, {31'b0, bus.busy}, 32'd0);
        last_result = exp;
    endtask

    initial begin
        logic [31:0] rb;
        int rn;
        logic [1:0] rm;
        bit seen;

        compared    = 0;
        mismatched  = 0;
        last_result = 32'h0;
        clock       = 1'b0;
        clear       = 1'b1;
        bus.start   = 1'b0;
        bus.B       = 32'hFFFF_FFFF;
        bus.shifts  = 5'd7;
        bus.mode    = 2'b01;

        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_result", bus.Result, 32'h0);
        clear = 1'b0;

        run_op(32'h8000_0000, 31, 2'b00, 32'h0000_0001, 0, "shr_max");
        run_op(32'h8000_0000, 4,  2'b01, 32'hF800_0000, 0, "shra_neg");
        run_op(32'h7FFF_FFFF, 4,  2'b01, 32'h07FF_FFFF, 0, "shra_pos");
`ifdef SHIFT_ROR_EN
        run_op(32'hA5A5_A5A5, 1,  2'b10, 32'hD2D2_D2D2, 0, "ror");
`else
        run_op(32'hA5A5_A5A5, 1,  2'b10, 32'h52D2_D2D2, 0, "ror_off");
`endif
        run_op(32'hDEAD_BEEF, 0,  2'b00, 32'hDEAD_BEEF, 0, "zero");
        run_op(32'hF000_000F, 8,  2'b11, 32'h00F0_0000, 0, "reserved");
        run_op(32'h1234_5678, 16, 2'b00, 32'h0000_1234, 3, "ignored_start");

        // Clear part-way through an operation.
        @(negedge clock);
        bus.start  = 1'b1;
        bus.B      = 32'h1234_5678;
        bus.shifts = 5'd16;
        bus.mode   = 2'b00;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        clear = 1'b1;
        @(posedge clock);
        #1;
        clear = 1'b0;
        check("clr_busy", {31'b0, bus.busy}, 32'd0);
        check("clr_done", {31'b0, bus.done}, 32'd0);
        check("clr_result", bus.Result, 32'h0);
        last_result = 32'h0;
        seen = 0;
        repeat (20) begin
            @(posedge clock);
            #1;
            if (bus.done) seen = 1;
        end
        check("clr_no_done", {31'b0, seen}, 32'd0);
        run_op(32'h8765_4321, 16, 2'b00, 32'h0000_8765, 0, "after_clr");

        for (int i = 0; i < 24; i++) begin
            rb = $urandom;
            rn = int'($urandom_range(0, 31));
            rm = 2'($urandom_range(0, 3));
            run_op(rb, rn, rm, ref_shift(rb, rn, rm), 0, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/shift_right_seq.md
# shift_right_seq

Multi-cycle right-shift unit for the datapath ALU, complementing the combinational left shifter. It performs logical (SHR), arithmetic (SHRA) and optionally rotate-right (ROR) operations on a 32-bit operand, one bit position per clock. A start/busy/done handshake lets the control unit stall while the shift runs. The registered result is held until the next accepted start.

## Interface
- WIDTH, 32: operand/result width.
- SHW, 5: shift-amount width, equal to log2(WIDTH).
- clock  input  1  rising-edge clock.
- clear  input  1  synchronous, active-high reset.
- start  input  1  request. Sampled only in IDLE.
- B  input  WIDTH  operand. Captured when start is accepted.
- shifts  input  SHW  shift amount, 0..31. Captured when start is accepted.
- mode  input  2  operation: 00 SHR, 01 SHRA, 10 ROR, 11 reserved (treated as SHR).
- busy  output  1  high from the accepted start through the DONE cycle.
- done  output  1  one-cycle pulse when Result is valid.
- Result  output  WIDTH  final value, held until the next accepted start.

## Operation
- States:
  - IDLE: busy=0.
  - SHIFT: busy=1.
  - DONE: busy=1, done=1.
- IDLE, start=1 → SHIFT:
  - acc←B, cnt←shifts, op←mode.
  - start=0 keeps the unit in IDLE.
- SHIFT with cnt≠0: acc←step(acc,op), cnt←cnt−1.
- SHIFT with cnt=0: Result←acc, go to DONE.
- DONE → IDLE unconditionally.
- step function:
  - SHR: {0, acc[31:1]}.
  - SHRA: {acc[31], acc[31:1]}.
  - ROR: {acc[0], acc[31:1]}.
- start is ignored while busy=1. No queueing.
- start in the same cycle the unit returns to IDLE is accepted on the next edge. There is no back-to-back acceptance in DONE.
- clear at any edge overrides everything:
  - state←IDLE; acc, cnt, Result←0.
  - busy=0, done=0.
  - An in-flight operation is discarded and no done is issued.
- B, shifts and mode may change freely after acceptance. Only the captured copies are used.

## Timing
- Reset values: busy=0, done=0, Result=0.
- Edge E0 accepts start, then:
  - E1..EN perform the N shifts.
  - E(N+1) loads Result and enters DONE, so done and Result are visible after E(N+1).
  - E(N+2) returns to IDLE.
- Latency from start edge to done is N+1 cycles. Range: 1 cycle (shifts=0) to 32 cycles (shifts=31).
- busy rises after E0 and falls after E(N+2).
- Result changes only at E(N+1) or on clear.

## Configuration
- SHIFT_ROR_EN:
  - Defined: mode 10 performs rotate-right.
  - Undefined: ROR logic is not compiled and mode 10 behaves exactly as SHR.
- Timing and handshake are identical in both builds.

## Structure
- Shared package shift_pkg holds:
  - Mode encodings: MODE_SHR=2'b00, MODE_SHRA=2'b01, MODE_ROR=2'b10.
  - State enum: IDLE, SHIFT, DONE.
  - WIDTH/SHW defaults.
- Sub-module shift_right_step: combinational one-position shifter taking acc and op and returning the next acc. The ROR branch is guarded by SHIFT_ROR_EN.
- Top level holds the FSM, counter, acc and Result registers.

## Test plan
- Reset: clear high 2 cycles → busy=0, done=0, Result=0x00000000.
- Logical, maximum latency: B=0x80000000, shifts=31, mode=SHR → Result=0x00000001; done seen 32 cycles after the start edge; exactly one done pulse.
- Arithmetic: B=0x80000000, shifts=4, mode=SHRA → 0xF8000000.
- Arithmetic, positive operand: B=0x7FFFFFFF, shifts=4, mode=SHRA → 0x07FFFFFF.
- Rotate: B=0xA5A5A5A5, shifts=1, mode=ROR:
  - With SHIFT_ROR_EN: 0xD2D2D2D2.
  - Without SHIFT_ROR_EN: 0x52D2D2D2.
- Zero shift: B=0xDEADBEEF, shifts=0 → 0xDEADBEEF; done one cycle after the start edge.
- Ignored start: start B=0x12345678, shifts=16; pulse start with B=0xFFFFFFFF at cycle 3 → Result=0x00001234.
- Clear mid-operation: start B=0x12345678, shifts=16; clear at cycle 5 → busy=0, Result=0, no done.
  - Then start B=0x87654321, shifts=16, SHR → 0x00008765.
